proc_trace_tx: RTL and testbench

- Execution-trace transmitter on the consuming side of the processor's result interface.
- Samples the processor outputs (op_code, dest_addr, dest_choice, alu_out) each clock while enabled.
- Queues each captured record in a small FIFO and serialises it as a framed byte stream over a UART-style 8N1 line.
- Used in simulation and on the board to observe retired instructions without a waveform dump.

---
 rtl/proc_trace_pkg.sv | 55 +++++
 rtl/proc_trace_tx_fifo.sv | 61 ++++++
 rtl/proc_trace_tx.sv | 176 +++++++++++++++++
 tb/tb_proc_trace_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_trace_pkg.sv
// Shared types and constants for the processor execution-trace transmitter.
// Optional build macro: TRACE_CHECKSUM_EN appends an XOR checksum byte to
// every frame (5-byte frames instead of 4).
package proc_trace_pkg;

  // First byte of every frame, lets a receiver resynchronise on a byte stream
  localparam logic [7:0] TRACE_SYNC = 8'hA5;

`ifdef TRACE_CHECKSUM_EN
  localparam int FRAME_BYTES = 5;
`else
  localparam int FRAME_BYTES = 4;
`endif

  // Width of the byte-within-frame index (covers up to 8 bytes)
  localparam int BYTE_IDX_W = 3;

  // One captured retirement record, already reduced to its transmitted fields
  typedef struct packed {
    logic [7:0] op_code;
    logic [1:0] dest_choice;
    logic [5:0] dest_addr;
    logic [7:0] value;
  } trace_rec_t;

  // Serialiser states
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Byte idx of the frame built from rec
  function automatic logic [7:0] frame_byte(input trace_rec_t rec,
                                            input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    // NOTE: assign a default before the case so every path drives b and no
    // latch is inferred when this is used in combinational context.
    b = TRACE_SYNC;
    case (idx)
      3'd0: b = TRACE_SYNC;
      3'd1: b = rec.op_code;
      3'd2: b = {rec.dest_choice, rec.dest_addr};
      3'd3: b = rec.value;
`ifdef TRACE_CHECKSUM_EN
      3'd4: b = rec.op_code ^ {rec.dest_choice, rec.dest_addr} ^ rec.value;
`endif
      default: b = TRACE_SYNC;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/proc_trace_tx_fifo.sv
// trace_fifo: synchronous record FIFO for the trace transmitter.
// Read data is the head record, visible combinationally before the pop.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module trace_fifo
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  trace_rec_t                 wr_data,
  output trace_rec_t                 rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  trace_rec_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Record storage
  // NOTE: the array is deliberately not reset; emptiness is defined by the
  // pointers and level, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/proc_trace_tx.sv
// proc_trace_tx: captures retired-instruction records from the processor
// result interface and sends each one as a framed 8N1 byte stream on tx.
// Frame: A5, op_code, {dest_choice, dest_addr[5:0]}, alu_out[7:0]
// (plus an XOR checksum byte when TRACE_CHECKSUM_EN is defined).
module proc_trace_tx
  import proc_trace_pkg::*;
#(
  parameter int OPCODE_WIDTH = 8,
  parameter int VALUE_WIDTH  = 8,
  parameter int MEM_WIDTH    = 8,
  parameter int NOP_CODE     = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cap_en,
  input  logic [OPCODE_WIDTH-1:0]       op_code,
  input  logic [VALUE_WIDTH-1:0]        alu_out,
  input  logic [MEM_WIDTH-1:0]          dest_addr,
  input  logic [1:0]                    dest_choice,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]         CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(FRAME_BYTES - 1);

  tx_state_t               state;
  trace_rec_t              cur_rec;
  trace_rec_t              cap_rec;
  trace_rec_t              fifo_rd;
  logic [7:0]              shift;
  logic [CW-1:0]           cnt;
  logic [2:0]              bit_idx;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    cap_push;
  logic                    cap_drop;
  logic                    bit_done;
  logic                    frame_end;
  logic                    unused_in_bits;

  // Only the low bits of the wide inputs are transmitted
  assign unused_in_bits = ^{op_code, alu_out, dest_addr};

  // Record as it will be queued: op_code zero-extended, address and value cut
  assign cap_rec = '{op_code:     8'(op_code),
                     dest_choice: dest_choice,
                     dest_addr:   6'(dest_addr),
                     value:       8'(alu_out)};

  assign cap_push  = cap_en && (op_code != OPCODE_WIDTH'(NOP_CODE));
  assign bit_done  = (cnt == CNT_LAST);
  assign frame_end = (state == STOP) && bit_done && (byte_idx == LAST_BYTE);
  // The next record is taken either from IDLE or straight off the end of a frame
  assign fifo_pop  = ((state == IDLE) || frame_end) && !fifo_empty;
  assign cap_drop  = cap_push && fifo_full && !fifo_pop;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cap_push),
    .pop     (fifo_pop),
    .wr_data (cap_rec),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Sticky drop flag; clearing wins over a same-edge drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end else if (cap_drop) begin
      overflow <= 1'b1;
    end
  end

  // Serialiser FSM: pops records and shifts each frame byte out as 8N1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_rec  <= '0;
      shift    <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            cur_rec  <= fifo_rd;
            byte_idx <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          shift <= frame_byte(cur_rec, byte_idx);
          cnt   <= '0;
          tx    <= 1'b0;
          state <= START;
        end

        START: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            shift   <= shift >> 1;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= LOAD;
            end else if (fifo_pop) begin
              cur_rec  <= fifo_rd;
              byte_idx <= '0;
              state    <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_trace_tx.sv
// Self-checking bench for proc_trace_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A free-running 8N1 receiver decodes tx into a byte queue; directed vectors
// and hand-written sequences compare decoded bytes and status outputs.
module tb_proc_trace_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FB    = proc_trace_pkg::FRAME_BYTES;
  localparam int FRAME_CLKS = FB * (10 * CPB + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cap_en = 1'b0;
  logic [7:0] op_code = '0;
  logic [7:0] alu_out = '0;
  logic [7:0] dest_addr = '0;
  logic [1:0] dest_choice = '0;
  logic       clr_ovf = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];

  proc_trace_tx #(
    .OPCODE_WIDTH (8),
    .VALUE_WIDTH  (8),
    .MEM_WIDTH    (8),
    .NOP_CODE     (0),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cap_en      (cap_en),
    .op_code     (op_code),
    .alu_out     (alu_out),
    .dest_addr   (dest_addr),
    .dest_choice (dest_choice),
    .clr_ovf     (clr_ovf),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    logic [7:0] op;
    logic [1:0] dc;
    logic [7:0] da;
    logic [7:0] alu;
    bit         frame;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
  } vec_t;

  vec_t vec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Receiver: samples at the negedge, one sample per bit period
  initial begin
    logic [7:0] b;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        b = '0;
        for (int k = 0; k < 9; k++) begin
          repeat (CPB) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (k < 8) b[k] = tx;
          else if (!aborted) check("stop_bit", {31'd0, tx}, 32'd1);
        end
        if (!aborted) rx_q.push_back(b);
      end
    end
  end

  task automatic drive(input bit en, input logic [7:0] op, input logic [1:0] dc,
                       input logic [7:0] da, input logic [7:0] al);
    cap_en      = en;
    op_code     = op;
    dest_choice = dc;
    dest_addr   = da;
    alu_out     = al;
  endtask

  task automatic wait_rx(input int n, input int limit, input string name);
    int k = 0;
    while (rx_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL %s: timeout, got %0d bytes, expected %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int limit, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy still high after %0d cycles", name, limit);
    end
  endtask

  function automatic logic [7:0] exp_byte(input vec_t v, input int idx);
    case (idx)
      0:       return 8'hA5;
      1:       return v.b1;
      2:       return v.b2;
      3:       return v.b3;
      default: return v.b1 ^ v.b2 ^ v.b3;
    endcase
  endfunction

  task automatic run_vec(input int v, input string tag);
    int txhi;
    @(negedge clk);
    drive(vec[v].en, vec[v].op, vec[v].dc, vec[v].da, vec[v].alu);
    @(negedge clk);
    cap_en = 1'b0;
    if (vec[v].frame) begin
      wait_rx(FB, FRAME_CLKS + 50, $sformatf("%s_rx", tag));
      for (int b = 0; b < FB; b++)
        check($sformatf("%s_byte%0d", tag, b),
              (b < rx_q.size()) ? {24'd0, rx_q[b]} : 32'h1FF, {24'd0, exp_byte(vec[v], b)});
      wait_idle(FRAME_CLKS, $sformatf("%s_idle", tag));
    end else begin
      check($sformatf("%s_level", tag), {28'd0, fifo_level}, 32'd0);
      txhi = 0;
      repeat (40) begin
        @(negedge clk);
        if (tx === 1'b1 && busy === 1'b0) txhi++;
      end
      check($sformatf("%s_tx_idle", tag), txhi, 40);
      check($sformatf("%s_no_bytes", tag), rx_q.size(), 0);
    end
    rx_q.delete();
  endtask

  initial begin
    int bc;
    int txhi;

    //           en  op     dc     da     alu    frame b1     b2     b3
    vec[0] = '{1'b1, 8'h03, 2'b01, 8'h0A, 8'h5C, 1'b1, 8'h03, 8'h4A, 8'h5C};
    vec[1] = '{1'b1, 8'h00, 2'b10, 8'h3F, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00};
    vec[2] = '{1'b0, 8'h07, 2'b11, 8'h15, 8'h11, 1'b0, 8'h00, 8'h00, 8'h00};
    vec[3] = '{1'b1, 8'hFF, 2'b11, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'h00};
    vec[4] = '{1'b1, 8'h80, 2'b10, 8'h41, 8'h7E, 1'b1, 8'h80, 8'h81, 8'h7E};
    vec[5] = '{1'b1, 8'h55, 2'b00, 8'hC0, 8'hA5, 1'b1, 8'h55, 8'h00, 8'hA5};

    // Power-on reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_level", {28'd0, fifo_level}, 32'd0);

    // Directed vector table
    for (int v = 0; v < 6; v++) run_vec(v, $sformatf("vec%0d", v));

    // Latency and busy length for a single capture at edge N
    @(negedge clk);
    drive(1'b1, 8'h03, 2'b01, 8'h0A, 8'h5C);
    @(negedge clk);
    cap_en = 1'b0;
    check("lat_n_level", {28'd0, fifo_level}, 32'd1);
    check("lat_n_busy", {31'd0, busy}, 32'd0);
    check("lat_n_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("lat_n1_busy", {31'd0, busy}, 32'd1);
    check("lat_n1_level", {28'd0, fifo_level}, 32'd0);
    check("lat_n1_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("lat_n2_tx", {31'd0, tx}, 32'd0);
    bc = 2;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      bc++;
    end
    check("busy_len", bc, FRAME_CLKS);
    wait_rx(FB, 50, "lat_rx");
    rx_q.delete();

    // Twelve back-to-back captures: 1 popped, 8 queued, 3 dropped
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(i), 2'b00, 8'(i), 8'(i * 3));
      @(posedge clk);
      @(negedge clk);
      cap_en = 1'b0;
      if (i == 1) check("ovr_lvl_e1", {28'd0, fifo_level}, 32'd1);
      if (i == 2) check("ovr_lvl_e2", {28'd0, fifo_level}, 32'd1);
      if (i == 9) begin
        check("ovr_lvl_e9", {28'd0, fifo_level}, 32'd8);
        check("ovr_flag_e9", {31'd0, overflow}, 32'd0);
      end
      if (i == 12) begin
        check("ovr_lvl_e12", {28'd0, fifo_level}, 32'd8);
        check("ovr_flag_e12", {31'd0, overflow}, 32'd1);
      end
    end
    wait_rx(9 * FB, 9 * FRAME_CLKS + 100, "ovr_rx");
    for (int k = 0; k < 9; k++)
      check($sformatf("ovr_frame%0d_op", k),
            (k * FB + 1 < rx_q.size()) ? {24'd0, rx_q[k * FB + 1]} : 32'h1FF, k + 1);
    wait_idle(FRAME_CLKS, "ovr_idle");
    repeat (60) @(negedge clk);
    check("ovr_total_bytes", rx_q.size(), 9 * FB);
    check("ovr_sticky", {31'd0, overflow}, 32'd1);
    rx_q.delete();

    // Plain clear
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_plain", {31'd0, overflow}, 32'd0);

    // Refill to full, then clear and drop on the same edge, then drop again
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(8'h20 + i), 2'b11, 8'h01, 8'(i));
      @(negedge clk);
    end
    check("fill_level", {28'd0, fifo_level}, 32'd8);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_vs_drop", {31'd0, overflow}, 32'd0);
    check("clr_vs_drop_lvl", {28'd0, fifo_level}, 32'd8);
    @(negedge clk);
    cap_en = 1'b0;
    check("drop_again", {31'd0, overflow}, 32'd1);

    // Reset roughly 20 cycles into the frame in flight
    repeat (8) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_level", {28'd0, fifo_level}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx_q.delete();
    txhi = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0) txhi++;
    end
    check("post_rst_quiet", txhi, 50);
    check("post_rst_no_bytes", rx_q.size(), 0);

    // Next frame after the reset is clean
    run_vec(0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
